// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the destination clock domain.
module gray_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    (* ASYNC_REG = "TRUE", keep = "true" *) logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= din;
            for (int unsigned i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/simple_dual_port_ram_reg1.sv
// Distributed RAM: one write port, one read port with a registered output, independent clocks.
module simple_dual_port_ram_reg1 #(
    parameter int WIDTH     = 8,
    parameter int SIZE_LOG2 = 4
) (
    input  logic                 wclock,
    input  logic                 wenable,
    input  logic [SIZE_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 rclock,
    input  logic                 renable,
    input  logic [SIZE_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [2**SIZE_LOG2];

    always_ff @(posedge wclock) begin
        if (wenable) mem[waddr] <= wdata;
    end

    always_ff @(posedge rclock) begin
        if (renable) rdata <= mem[raddr];
    end

endmodule

// File: rtl/push_to_axis_async.sv
// Dual-clock FIFO: clock-enabled push on wclock, AXI-stream drain on rclock, Gray pointer crossing.
module push_to_axis_async #(
    parameter int WIDTH       = 8,
    parameter int SIZE_LOG2   = 4,
    parameter int AFULL_LIMIT = 1 << (SIZE_LOG2 - 1),
    parameter int SYNC_STAGES = 2
) (
    input  logic             wclock,
    input  logic             resetn,
    input  logic             rclock,
    input  logic [WIDTH-1:0] idata,
    input  logic             ienable,
    output logic             iafull,
    output logic             overflow,
    output logic [WIDTH-1:0] odata,
    output logic             ovalid,
    input  logic             oready
);

    localparam int PW    = SIZE_LOG2 + 1;
    localparam int DEPTH = 1 << SIZE_LOG2;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int unsigned i = PW - 1; i > 0; i--) b[i-1] = b[i] ^ g[i-1];
        return b;
    endfunction

    logic [PW-1:0] wptr, wptr_next, wptr_gray, wptr_gray_r, wptr_r;
    logic [PW-1:0] rptr, rptr_next, rptr_gray, rptr_gray_w, rptr_w;
    logic [PW-1:0] wlevel;
    logic          full, push, empty, renable;

    // Write domain
    assign rptr_w    = gray2bin(rptr_gray_w);
    assign wlevel    = wptr - rptr_w;
    assign full      = (wlevel == PW'(DEPTH));
    assign push      = ienable && !full;
    assign wptr_next = wptr + PW'(push);

    // Gray copy is loaded from the next pointer so it moves on the same edge as wptr.
    always_ff @(posedge wclock or negedge resetn) begin
        if (!resetn) begin
            wptr      <= '0;
            wptr_gray <= '0;
            overflow  <= 1'b0;
            iafull    <= 1'b1;
        end else begin
            wptr      <= wptr_next;
            wptr_gray <= bin2gray(wptr_next);
            iafull    <= (int'(wlevel) >= AFULL_LIMIT);
            if (ienable && full) overflow <= 1'b1;
        end
    end

    gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_rptr_sync (
        .clock  (wclock),
        .resetn (resetn),
        .din    (rptr_gray),
        .dout   (rptr_gray_w)
    );

    // Read domain
    assign wptr_r    = gray2bin(wptr_gray_r);
    assign empty     = (wptr_r == rptr);
    assign renable   = !empty && (!ovalid || oready);
    assign rptr_next = rptr + PW'(renable);

    always_ff @(posedge rclock or negedge resetn) begin
        if (!resetn) begin
            rptr      <= '0;
            rptr_gray <= '0;
            ovalid    <= 1'b0;
        end else begin
            rptr      <= rptr_next;
            rptr_gray <= bin2gray(rptr_next);
            ovalid    <= renable || (ovalid && !oready);
        end
    end

    gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_wptr_sync (
        .clock  (rclock),
        .resetn (resetn),
        .din    (wptr_gray),
        .dout   (wptr_gray_r)
    );

    simple_dual_port_ram_reg1 #(.WIDTH(WIDTH), .SIZE_LOG2(SIZE_LOG2)) u_ram (
        .wclock  (wclock),
        .wenable (push),
        .waddr   (wptr[SIZE_LOG2-1:0]),
        .wdata   (idata),
        .rclock  (rclock),
        .renable (renable),
        .raddr   (rptr[SIZE_LOG2-1:0]),
        .rdata   (odata)
    );

endmodule
